// File: rtl/line_pkg.sv
// Shared types and helpers for the Bresenham line rasteriser and its step datapath.
package line_pkg;

   localparam int COORD_W_DEF = 11;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      PLOT,
      DONE
   } state_t;

   typedef logic [COORD_W_DEF-1:0]        coord_t;
   typedef logic signed [COORD_W_DEF+1:0] err_t;

   // Operates on 32-bit operands so instances with any coordinate width can share it.
   function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/line_step.sv
// One combinational Bresenham step: both axis tests use the pre-step error term.
module line_step #(
   parameter int COORD_W = 11
) (
   input  logic [COORD_W-1:0]        x,
   input  logic [COORD_W-1:0]        y,
   input  logic signed [COORD_W+1:0] err,
   input  logic signed [COORD_W:0]   dx,
   input  logic signed [COORD_W:0]   dy,
   input  logic                      sx,
   input  logic                      sy,
   output logic [COORD_W-1:0]        x_next,
   output logic [COORD_W-1:0]        y_next,
   output logic signed [COORD_W+1:0] err_next
);

   localparam logic [COORD_W-1:0] ONE = 1;

   logic signed [COORD_W+2:0] e2;
   logic signed [COORD_W+2:0] dx_e;
   logic signed [COORD_W+2:0] dy_e;
   logic signed [COORD_W+1:0] dx_w;
   logic signed [COORD_W+1:0] dy_w;
   logic                      step_x;
   logic                      step_y;

   assign e2     = $signed({err, 1'b0});
   assign dx_e   = (COORD_W+3)'(dx);
   assign dy_e   = (COORD_W+3)'(dy);
   assign dx_w   = (COORD_W+2)'(dx);
   assign dy_w   = (COORD_W+2)'(dy);
   assign step_x = (e2 >= dy_e);
   assign step_y = (e2 <= dx_e);

   // sx/sy set means the walker moves toward the smaller coordinate on that axis.
   always_comb begin
      err_next = err;
      x_next   = x;
      y_next   = y;
      if (step_x) begin
         err_next = err_next + dy_w;
         x_next   = sx ? (x - ONE) : (x + ONE);
      end
      if (step_y) begin
         err_next = err_next + dx_w;
         y_next   = sy ? (y - ONE) : (y + ONE);
      end
   end

endmodule

// File: rtl/line_raster_stream.sv
// Bresenham line rasteriser: start/busy command port in, valid/ready pixel stream out.
// Define LINE_CLIP_EN to walk but suppress pixels beyond X_MAX/Y_MAX.
module line_raster_stream
   import line_pkg::*;
#(
   parameter int COORD_W = 11,
   parameter int X_MAX   = 639,
   parameter int Y_MAX   = 479
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   output logic               busy,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_last,
   output logic               done
);

`ifdef LINE_CLIP_EN
   localparam bit CLIP_ON = 1'b1;
`else
   localparam bit CLIP_ON = 1'b0;
`endif

   localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

   state_t                    state;
   logic [COORD_W-1:0]        x0_r;
   logic [COORD_W-1:0]        y0_r;
   logic [COORD_W-1:0]        x1_r;
   logic [COORD_W-1:0]        y1_r;
   logic [COORD_W-1:0]        x;
   logic [COORD_W-1:0]        y;
   logic signed [COORD_W:0]   dx;
   logic signed [COORD_W:0]   dy;
   logic signed [COORD_W:0]   dx_c;
   logic signed [COORD_W:0]   dy_c;
   logic                      sx;
   logic                      sy;
   logic signed [COORD_W+1:0] err;
   logic signed [COORD_W+1:0] err_c;
   logic signed [COORD_W+1:0] err_next;
   logic [COORD_W-1:0]        x_next;
   logic [COORD_W-1:0]        y_next;
   logic                      at_end;
   logic                      advance;
   logic                      start_is_end;
   logic                      next_is_end;

   function automatic logic visible(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py);
      return !CLIP_ON || ((px <= X_LIM) && (py <= Y_LIM));
   endfunction

   assign dx_c  = $signed((COORD_W+1)'(abs_diff(32'(x0_r), 32'(x1_r))));
   assign dy_c  = -$signed((COORD_W+1)'(abs_diff(32'(y0_r), 32'(y1_r))));
   assign err_c = (COORD_W+2)'(dx_c) + (COORD_W+2)'(dy_c);

   assign start_is_end = (x0_r == x1_r) && (y0_r == y1_r);
   assign next_is_end  = (x_next == x1_r) && (y_next == y1_r);

   // A clipped pixel is never offered, so the walker must not wait on pix_ready for it.
   assign advance = (state == PLOT) && (!pix_valid || pix_ready);

   assign pix_x = x;
   assign pix_y = y;

   line_step #(
      .COORD_W (COORD_W)
   ) u_step (
      .x        (x),
      .y        (y),
      .err      (err),
      .dx       (dx),
      .dy       (dy),
      .sx       (sx),
      .sy       (sy),
      .x_next   (x_next),
      .y_next   (y_next),
      .err_next (err_next)
   );

   // Command latch, setup, pixel walk and done pulse; every output is a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
         done      <= 1'b0;
         x         <= '0;
         y         <= '0;
         x0_r      <= '0;
         y0_r      <= '0;
         x1_r      <= '0;
         y1_r      <= '0;
         dx        <= '0;
         dy        <= '0;
         sx        <= 1'b0;
         sy        <= 1'b0;
         err       <= '0;
         at_end    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x0_r  <= x0;
                  y0_r  <= y0;
                  x1_r  <= x1;
                  y1_r  <= y1;
                  busy  <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               dx        <= dx_c;
               dy        <= dy_c;
               sx        <= (x1_r < x0_r);
               sy        <= (y1_r < y0_r);
               err       <= err_c;
               x         <= x0_r;
               y         <= y0_r;
               at_end    <= start_is_end;
               pix_valid <= visible(x0_r, y0_r);
               pix_last  <= start_is_end && visible(x0_r, y0_r);
               state     <= PLOT;
            end
            PLOT: begin
               if (advance) begin
                  if (at_end) begin
                     pix_valid <= 1'b0;
                     pix_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     x         <= x_next;
                     y         <= y_next;
                     err       <= err_next;
                     at_end    <= next_is_end;
                     pix_valid <= visible(x_next, y_next);
                     pix_last  <= next_is_end && visible(x_next, y_next);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_raster_stream.sv
// Scoreboard bench for line_raster_stream: directed and random lines against a Bresenham reference.
module tb_line_raster_stream;

   localparam int W  = 11;
   localparam int XM = 639;
   localparam int YM = 479;

   typedef struct {
      int x;
      int y;
      bit last;
   } pix_t;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         start     = 1'b0;
   logic         pix_ready = 1'b1;
   logic [W-1:0] x0 = '0;
   logic [W-1:0] y0 = '0;
   logic [W-1:0] x1 = '0;
   logic [W-1:0] y1 = '0;
   logic         busy;
   logic         pix_valid;
   logic         pix_last;
   logic         done;
   logic [W-1:0] pix_x;
   logic [W-1:0] pix_y;

   int   errors = 0;
   int   checks = 0;
   pix_t expq[$];
   pix_t mon_p;
   int   cyc = 0;
   bit   rand_ready = 1'b0;
   int   hs_cnt = 0;
   int   done_cnt = 0;
   int   busy_cnt = 0;
   bit   lat_armed = 1'b0;
   int   lat_start = 0;
   int   last_hs_cyc = -10;
   bit   last_hs_final = 1'b0;
   int   last_px = 0;
   int   last_py = 0;
   bit   prev_stall = 1'b0;
   logic [W-1:0] prev_x = '0;
   logic [W-1:0] prev_y = '0;
   logic         prev_last = 1'b0;

   line_raster_stream #(
      .COORD_W (W),
      .X_MAX   (XM),
      .Y_MAX   (YM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .x0        (x0),
      .y0        (y0),
      .x1        (x1),
      .y1        (y1),
      .busy      (busy),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_last  (pix_last),
      .done      (done)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic bit visibleModel(input int px, input int py);
`ifdef LINE_CLIP_EN
      return (px <= XM) && (py <= YM);
`else
      return 1'b1;
`endif
   endfunction

   // Reference walk with plain integers; returns the unclipped pixel count max(|dx|,|dy|)+1.
   function automatic int buildModel(input int ax0, input int ay0, input int ax1, input int ay1);
      int px = ax0;
      int py = ay0;
      int adx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
      int ady = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
      int mdy = -ady;
      int stx = (ax1 >= ax0) ? 1 : -1;
      int sty = (ay1 >= ay0) ? 1 : -1;
      int e = adx + mdy;
      int e2;
      for (int n = 0; n < 5000; n++) begin
         if (visibleModel(px, py))
            expq.push_back('{px, py, (px == ax1 && py == ay1)});
         if (px == ax1 && py == ay1)
            break;
         e2 = 2 * e;
         if (e2 >= mdy) begin
            e  += mdy;
            px += stx;
         end
         if (e2 <= adx) begin
            e  += adx;
            py += sty;
         end
      end
      return ((adx > ady) ? adx : ady) + 1;
   endfunction

   // Monitor: pops the scoreboard on each handshake and checks hold, latency and done timing.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (busy)
            busy_cnt++;
         if (prev_stall)
            checkOutput("hold under backpressure", {pix_valid, pix_last, pix_x, pix_y},
                        {1'b1, prev_last, prev_x, prev_y});
         if (lat_armed && pix_valid) begin
            checkOutput("first pixel latency", cyc - lat_start, 2);
            lat_armed = 1'b0;
         end
         if (pix_valid && pix_ready) begin
            hs_cnt++;
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("[TB] FAIL pixel: got unexpected (%0d,%0d,last=%0b) with empty scoreboard",
                        pix_x, pix_y, pix_last);
            end else begin
               mon_p = expq.pop_front();
               if (pix_x !== W'(mon_p.x) || pix_y !== W'(mon_p.y) || pix_last !== mon_p.last) begin
                  errors++;
                  $display("[TB] FAIL pixel: got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                           pix_x, pix_y, pix_last, mon_p.x, mon_p.y, mon_p.last);
               end
            end
            last_hs_cyc   = cyc;
            last_hs_final = pix_last;
            last_px       = int'(pix_x);
            last_py       = int'(pix_y);
         end
         if (done) begin
            done_cnt++;
            if (last_hs_final)
               checkOutput("done one cycle after last", cyc, last_hs_cyc + 1);
         end
         prev_stall = pix_valid && !pix_ready;
         prev_x     = pix_x;
         prev_y     = pix_y;
         prev_last  = pix_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1, input bit rnd);
      int  expected_hs;
      int  hs0;
      bit  seen;
      expected_hs = buildModel(ax0, ay0, ax1, ay1);
`ifdef LINE_CLIP_EN
      expected_hs = expq.size();
`endif
      @(posedge clk);
      #1;
      rand_ready    = rnd;
      x0            = W'(ax0);
      y0            = W'(ay0);
      x1            = W'(ax1);
      y1            = W'(ay1);
      start         = 1'b1;
      hs0           = hs_cnt;
      busy_cnt      = 0;
      last_hs_final = 1'b0;
      lat_armed     = (expq.size() > 0) && (expq[0].x == ax0) && (expq[0].y == ay0);
      lat_start     = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done timeout: line (%0d,%0d)->(%0d,%0d) got no done, required one",
                  ax0, ay0, ax1, ay1);
      end
      checkOutput("handshake count", hs_cnt - hs0, expected_hs);
      checkOutput("scoreboard drained", expq.size(), 0);
      expq.delete();
      rand_ready = 1'b0;
   endtask

   initial begin
      int dc;
      int unused_n;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset pix_valid", pix_valid, 0);
      checkOutput("reset pix_last", pix_last, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset pix_x", pix_x, 0);
      checkOutput("reset pix_y", pix_y, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      applyStimulus(0, 0, 4, 2, 1'b0);
      applyStimulus(10, 10, 7, 13, 1'b0);
      applyStimulus(5, 5, 5, 5, 1'b0);
      checkOutput("busy cycles single pixel", busy_cnt, 2);
      applyStimulus(40, 200, 160, 0, 1'b1);
      checkOutput("final pixel x", last_px, 160);
      checkOutput("final pixel y", last_py, 0);

      // Ignored second start, then reset mid-line.
      unused_n = buildModel(0, 0, 100, 50);
      @(posedge clk);
      #1;
      x0 = W'(0);
      y0 = W'(0);
      x1 = W'(100);
      y1 = W'(50);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      x0 = W'(200);
      y0 = W'(200);
      x1 = W'(0);
      y1 = W'(0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      dc    = done_cnt;
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset mid-line pix_valid", pix_valid, 0);
      checkOutput("reset mid-line busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      expq.delete();
      repeat (4) @(negedge clk);
      checkOutput("no done after abandon", done_cnt, dc);
      applyStimulus(3, 7, 20, 1, 1'b1);

`ifdef LINE_CLIP_EN
      applyStimulus(630, 0, 650, 0, 1'b0);
`endif

      for (int i = 0; i < 6; i++)
         applyStimulus($urandom_range(0, 700), $urandom_range(0, 520),
                       $urandom_range(0, 700), $urandom_range(0, 520), 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/line_raster_stream.md
Name: line_raster_stream

Overview:
- Parametrised Bresenham rasteriser. Accepts one line command (two endpoints) through a start/busy handshake.
- Emits every pixel of the line, both endpoints included, as a valid/ready stream at up to one pixel per cycle, with full backpressure.
- Sits between the draw-command source and the framebuffer write port.
- Next generation of the fixed-width line drawer: adds configurable coordinate width, a command handshake, a flow-controlled pixel stream, a last-pixel marker and optional clipping.

Parameters:
- COORD_W, 11, bit width of each unsigned coordinate.
- X_MAX, 639, rightmost visible column; used only with LINE_CLIP_EN.
- Y_MAX, 479, bottom visible row; used only with LINE_CLIP_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- x0, y0  in  COORD_W each  start point.
- x1, y1  in  COORD_W each  end point.
- busy  out  1  high from the cycle after start is accepted until done.
- pix_valid  out  1  pix_x/pix_y hold a pixel.
- pix_ready  in  1  sink accepts the pixel this cycle.
- pix_x, pix_y  out  COORD_W each  pixel coordinate.
- pix_last  out  1  qualifies the final pixel of the line.
- done  out  1  one-cycle pulse after the final pixel is accepted.

Behaviour:
- Reset values: busy, pix_valid, pix_last, done = 0; pix_x, pix_y = 0; state = IDLE. Reset overrides everything.
- Reset mid-line: the line is abandoned, no done pulse, next cycle is IDLE.
- States: IDLE, SETUP, PLOT, DONE.
- IDLE: start=1 latches x0..y1 and moves to SETUP. start in any other state is ignored; there is no command queue.
- SETUP (1 cycle): compute the following from the latched endpoints, then load x=x0, y=y0 and go to PLOT.
  - dx = |x1-x0|
  - dy = -|y1-y0|
  - sx = +1 if x1>=x0, else -1
  - sy = +1 if y1>=y0, else -1
  - err = dx+dy
- Latency: start accepted at cycle N; first pix_valid at N+2.
- PLOT: pix_valid=1 with pix_x=x, pix_y=y, pix_last=(x==x1 && y==y1).
  - Outputs stay stable while pix_ready=0.
  - On a handshake (pix_valid && pix_ready):
    - if pix_last, go to DONE;
    - else step with e2 = 2*err, using the pre-step err for both tests: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both may apply in the same cycle.
- DONE: done=1 for one cycle, pix_valid=0, then IDLE. A start in the following IDLE cycle is accepted normally.
- Pixel count = max(dx,-dy)+1. A zero-length line emits exactly one pixel, with pix_last=1.
- Arithmetic widths:
  - dx, dy: signed COORD_W+1.
  - err: signed COORD_W+2.
  - e2: signed COORD_W+3.
  - No overflow is possible for any endpoints in [0, 2^COORD_W-1].
  - x and y never step past x1/y1.
- busy = (state != IDLE) && (state != DONE).

Optional Feature:
- Macro LINE_CLIP_EN.
- Defined:
  - A pixel with x>X_MAX or y>Y_MAX is walked internally but not emitted. pix_valid=0 for that cycle and the walker advances without waiting for pix_ready.
  - pix_last is asserted only if the endpoint is visible.
  - If every pixel is clipped, no pixel is emitted, but done still pulses.
  - Traversal order and step count are unchanged.
- Undefined: every pixel is emitted; X_MAX and Y_MAX are ignored.

Decomposition:
- Package line_pkg holds:
  - state enum (IDLE, SETUP, PLOT, DONE);
  - typedefs coord_t (COORD_W) and err_t (COORD_W+2), sized from package-level defaults;
  - abs-difference function.
- Sub-module line_step: combinational, one Bresenham step.
  - Inputs: x, y, err, dx, dy, sx, sy.
  - Outputs: next x, y, err.
  - Lets verification check stepping in isolation.

Test Plan:
- (0,0)->(4,2), pix_ready tied 1:
  - pixels (0,0),(1,1),(2,1),(3,2),(4,2) on consecutive cycles starting N+2;
  - pix_last on (4,2); done at the following cycle.
- (10,10)->(7,13): pixels (10,10),(9,11),(8,12),(7,13); checks negative sx.
- (5,5)->(5,5): single pixel (5,5) with pix_last=1, then done; busy high for exactly 2 cycles.
- (40,200)->(160,0) with pix_ready random 50%:
  - exactly 201 handshakes;
  - pixel outputs never change while pix_valid=1 and pix_ready=0;
  - final pixel (160,0).
- Second start while busy, then reset asserted mid-line:
  - second start ignored;
  - after reset, pix_valid=0 and busy=0 next cycle, no done;
  - a fresh command completes correctly.
- LINE_CLIP_EN, X_MAX=639: (630,0)->(650,0):
  - emits (630,0)..(639,0), 10 pixels, none with pix_last;
  - done pulses after the walker reaches (650,0).
